// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous transmit FIFO between the bus TX-data register write and the
//   UART transmitter. Bytes written by the bus are queued. The head byte is
//   presented on a registered dout one cycle after an accepted read strobe.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous, active-low reset
//   flush      in   synchronous clear of contents, pointers and flags
//   wdata      in   byte to write
//   we         in   write strobe, active-high, one byte per cycle
//   re_n       in   read strobe, active-low
//   dout       out  registered head byte (holds between reads)
//   empty      out  no bytes stored
//   full       out  DEPTH bytes stored
//   afull      out  count >= AFULL_LEVEL
//   count      out  bytes stored, 0..DEPTH
//   overflow   out  sticky: write attempted while full
//   underflow  out  sticky: read attempted while empty
//   clr_flags  in   synchronous clear of overflow/underflow
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  input  logic                  re_n,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic                  afull,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_flags
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   AFULL_CNT = AFULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic                rd_acc;
  logic                wr_acc;
  logic                rd_err;
  logic                wr_err;
  logic [ADDR_WIDTH:0] rd_inc;

  // The read is decided first; a write into a full FIFO is accepted when the
  // same edge also pops a byte, so the full test uses the post-read count.
  assign rd_acc = ~re_n & (count != '0);
  assign rd_err = ~re_n & (count == '0);
  assign rd_inc = {{ADDR_WIDTH{1'b0}}, rd_acc};
  assign wr_acc = we & ((count - rd_inc) != DEPTH_CNT);
  assign wr_err = we & ~wr_acc;

  // Status decoded straight from the registered count.
  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign afull = (count >= AFULL_CNT);

  // NOTE: the storage array has no reset; stale entries are never visible
  // because dout only loads from slots that count says are occupied.
  always_ff @(posedge clk) begin
    if (!flush && wr_acc) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours (e.g. dout reads the old rd_ptr).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (rd_acc) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      // A new error event in the same cycle beats clr_flags.
      if (wr_err) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end

      if (rd_err) begin
        underflow <= 1'b1;
      end else if (clr_flags) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo: a vector table for the basic write/read
//   sequence, then hand-written sequences for fill/overflow, read+write while
//   full, underflow with same-cycle write, pointer wrap, flush and async reset.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic [7:0] wdata;
  logic       we;
  logic       re_n;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic       afull;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       clr_flags;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .AFULL_LEVEL(12)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .wdata    (wdata),
    .we       (we),
    .re_n     (re_n),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .afull    (afull),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow),
    .clr_flags(clr_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] wdata;
    logic       re_n;
    logic       flush;
    logic       clr;
    logic [7:0] e_dout;
    logic [4:0] e_count;
    logic       e_empty;
    logic       e_full;
    logic       e_afull;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [7:0] e_dout,
                             input logic [4:0] e_count, input logic e_empty,
                             input logic e_full, input logic e_afull,
                             input logic e_ovf, input logic e_unf);
    check({name, ".dout"},      32'(dout),      32'(e_dout));
    check({name, ".count"},     32'(count),     32'(e_count));
    check({name, ".empty"},     32'(empty),     32'(e_empty));
    check({name, ".full"},      32'(full),      32'(e_full));
    check({name, ".afull"},     32'(afull),     32'(e_afull));
    check({name, ".overflow"},  32'(overflow),  32'(e_ovf));
    check({name, ".underflow"}, 32'(underflow), 32'(e_unf));
  endtask

  // Drive one cycle of inputs, step past the rising edge, sample at +1,
  // then return inputs to idle.
  task automatic cycle(input logic we_i, input logic [7:0] d_i, input logic re_n_i,
                       input logic flush_i, input logic clr_i);
    we        = we_i;
    wdata     = d_i;
    re_n      = re_n_i;
    flush     = flush_i;
    clr_flags = clr_i;
    @(posedge clk);
    #1;
    we        = 1'b0;
    wdata     = 8'h00;
    re_n      = 1'b1;
    flush     = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] d);
    cycle(1'b1, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_read();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  logic [7:0] q [$];
  logic [7:0] exp_dout;
  bit         rd_now;

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    wdata     = 8'h00;
    we        = 1'b0;
    re_n      = 1'b1;
    clr_flags = 1'b0;

    // Test 1 table: three writes, three reads, one read on empty, then clear.
    //            we    wdata  re_n  flush clr   dout   cnt    emp   full  afull ovf   unf
    vecs[0] = '{1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 8'h00, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 8'h00, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h42, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h43, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h43, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h43, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].we, vecs[i].wdata, vecs[i].re_n, vecs[i].flush, vecs[i].clr);
      check_state($sformatf("t1_vec%0d", i), vecs[i].e_dout, vecs[i].e_count,
                  vecs[i].e_empty, vecs[i].e_full, vecs[i].e_afull,
                  vecs[i].e_ovf, vecs[i].e_unf);
    end

    // Test 2: fill 0x00..0x0F, watch afull/full thresholds, overflow, drain.
    for (int i = 0; i < 16; i++) begin
      do_write(8'(i));
      check($sformatf("t2_fill%0d.count", i), 32'(count), 32'(i + 1));
      check($sformatf("t2_fill%0d.afull", i), 32'(afull), 32'((i + 1) >= 12));
      check($sformatf("t2_fill%0d.full", i),  32'(full),  32'((i + 1) == 16));
    end
    do_write(8'hFF);
    check_state("t2_ovf", 8'h43, 5'd16, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      do_read();
      check($sformatf("t2_drain%0d.dout", i), 32'(dout), 32'(i));
    end
    check_state("t2_empty", 8'h0F, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("t2_clr.overflow", 32'(overflow), 32'd0);

    // Test 3: full FIFO, simultaneous write+read is accepted.
    for (int i = 0; i < 16; i++) do_write(8'(i));
    check("t3_full", 32'(full), 32'd1);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    check_state("t3_rw", 8'h00, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      do_read();
      check($sformatf("t3_drain%0d.dout", i), 32'(dout), 32'(i));
    end
    do_read();
    check("t3_last.dout", 32'(dout), 32'hA5);
    check("t3_last.empty", 32'(empty), 32'd1);

    // Test 4: underflow, then read+write on empty, then clear.
    do_read();
    check_state("t4_unf", 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    check_state("t4_rw_empty", 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("t4_clr.underflow", 32'(underflow), 32'd0);
    // Error in the same cycle as clr_flags: the new event wins.
    do_read();
    check("t4_read.dout", 32'(dout), 32'h5A);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t4_clr_vs_err.underflow", 32'(underflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("t4_clr2.underflow", 32'(underflow), 32'd0);

    // Test 5: 20 writes with reads on alternate cycles, forcing pointer wrap.
    q.delete();
    exp_dout = 8'h5A;
    for (int i = 0; i < 20; i++) begin
      rd_now = (i % 2) == 1;
      if (rd_now && q.size() != 0) exp_dout = q.pop_front();
      q.push_back(8'(8'h80 + i));
      cycle(1'b1, 8'(8'h80 + i), rd_now ? 1'b0 : 1'b1, 1'b0, 1'b0);
      check($sformatf("t5_mix%0d.dout", i),  32'(dout),  32'(exp_dout));
      check($sformatf("t5_mix%0d.count", i), 32'(count), 32'(q.size()));
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      exp_dout = q.pop_front();
      do_read();
      check($sformatf("t5_drain%0d.dout", i), 32'(dout), 32'(exp_dout));
    end
    check("t5_end.empty", 32'(empty), 32'd1);
    check("t5_end.underflow", 32'(underflow), 32'd0);

    // Test 6a: flush beats we/re_n and clears sticky flags.
    do_read();
    check("t6_pre.underflow", 32'(underflow), 32'd1);
    for (int i = 0; i < 5; i++) do_write(8'(8'h10 + i));
    do_read();
    check("t6_pre.dout", 32'(dout), 32'h10);
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    check_state("t6_flush", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_write(8'h99);
    do_read();
    check("t6_post_flush.dout", 32'(dout), 32'h99);

    // Test 6b: async reset mid-operation, checked before any clock edge.
    for (int i = 0; i < 5; i++) do_write(8'(8'h20 + i));
    do_read();
    check("t6_prerst.dout", 32'(dout), 32'h20);
    #2;
    reset_n = 1'b0;
    #1;
    check_state("t6_async_rst", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    do_write(8'h3C);
    do_read();
    check_state("t6_after_rst", 8'h3C, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
